safe_obi_mem_responder: RTL and testbench



---
 rtl/safe_obi_mem_responder.sv | 123 ++++++++++++
 tb/tb_safe_obi_mem_responder.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/safe_obi_mem_responder.sv
// OBI slave responder: word-addressed scratch memory, fixed read latency, post-reset clear.
// Optional random wait-states via `define SAFE_OBI_RESP_STALL_EN (16-bit LFSR gates gnt).
package safe_obi_pkg;
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;
endpackage

module safe_obi_mem_responder
  import safe_obi_pkg::*;
#(
  parameter int          NUM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          LATENCY   = 1,
  parameter logic [31:0] ERR_RDATA = 32'hBADC_AB1E
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  obi_req_t  obi_req_i,
  output obi_resp_t obi_resp_o,
  output logic      init_done_o,
  output logic      oor_o
);
  localparam int AW = $clog2(NUM_WORDS);

  typedef enum logic {INIT, READY} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [31:0]     mem [NUM_WORDS];
  logic            stall, gnt, in_range;
  logic [AW-1:0]   widx;
  logic [31:0]     rsp_data;
  logic [LATENCY:1]       vld_pipe;
  logic [LATENCY:1][31:0] dat_pipe;

  // 33-bit compare so BASE_ADDR + NUM_WORDS*4 cannot wrap at the top of the map
  logic [32:0] addr_ext, lo_bound, hi_bound;
  assign addr_ext = {1'b0, obi_req_i.addr};
  assign lo_bound = {1'b0, BASE_ADDR};
  assign hi_bound = lo_bound + 33'(NUM_WORDS * 4);
  assign in_range = (addr_ext >= lo_bound) && (addr_ext < hi_bound);
  assign widx     = AW'((obi_req_i.addr - BASE_ADDR) >> 2);

`ifdef SAFE_OBI_RESP_STALL_EN
  logic [15:0] lfsr_q;
  always_ff @(posedge clk_i) begin
    if (rst_i)                lfsr_q <= 16'hACE1;
    else if (state_q == READY) lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end
  assign stall = lfsr_q[0];
`else
  assign stall = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      INIT: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == AW'(NUM_WORDS - 1)) state_d = READY;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= INIT;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Reset outranks any request presented in the same cycle
  assign gnt = obi_req_i.req && (state_q == READY) && !stall && !rst_i;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (state_q == INIT) begin
        mem[idx_q] <= '0;
      end else if (gnt && obi_req_i.we && in_range) begin
        for (int b = 0; b < 4; b++)
          if (obi_req_i.be[b]) mem[widx][8*b +: 8] <= obi_req_i.wdata[8*b +: 8];
      end
    end
  end

  assign rsp_data = obi_req_i.we ? 32'h0 : (in_range ? mem[widx] : ERR_RDATA);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[1] <= gnt;
      for (int s = 2; s <= LATENCY; s++) vld_pipe[s] <= vld_pipe[s-1];
    end
  end

  always_ff @(posedge clk_i) begin
    dat_pipe[1] <= rsp_data;
    for (int s = 2; s <= LATENCY; s++) dat_pipe[s] <= dat_pipe[s-1];
  end

  assign obi_resp_o.gnt    = gnt;
  assign obi_resp_o.rvalid = vld_pipe[LATENCY] && !rst_i;
  assign obi_resp_o.rdata  = obi_resp_o.rvalid ? dat_pipe[LATENCY] : 32'h0;
  assign init_done_o       = (state_q == READY);
  assign oor_o             = gnt && !in_range;
endmodule

// File: tb/tb_safe_obi_mem_responder.sv
// Scoreboard bench for safe_obi_mem_responder: random OBI traffic against an array model.
module tb_safe_obi_mem_responder;
  import safe_obi_pkg::*;

  localparam int          NW   = 64;
  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int          LAT  = 3;
  localparam logic [31:0] ERR  = 32'hBADC_AB1E;

  logic      clk = 1'b0;
  logic      rst = 1'b0;
  obi_req_t  req;
  obi_resp_t resp;
  logic      init_done, oor;

  always #5 clk = ~clk;

  safe_obi_mem_responder #(.NUM_WORDS(NW), .BASE_ADDR(BASE), .LATENCY(LAT), .ERR_RDATA(ERR)) dut (
    .clk_i(clk), .rst_i(rst), .obi_req_i(req), .obi_resp_o(resp),
    .init_done_o(init_done), .oor_o(oor)
  );

  typedef struct { logic [31:0] data; int due; } exp_t;
  exp_t        q[$];
  logic [31:0] mm [NW];
  int          checks = 0, errors = 0, cyc = 0;
  int          init_cnt = 0;
  logic [15:0] lfsr_m = 16'hACE1;
  bit          started = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit in_rng(logic [31:0] a);
    longint x = longint'(a);
    return (x >= longint'(BASE)) && (x < longint'(BASE) + NW * 4);
  endfunction

  // Time-since-reset model: clear takes NW cycles, then the LFSR runs each ready cycle
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      init_cnt = 0;
      lfsr_m   = 16'hACE1;
    end else if (init_cnt < NW) init_cnt++;
    else lfsr_m = {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
  end

  // Monitor: grant/init timing every cycle, responses popped from the scoreboard
  always @(negedge clk) begin
    logic eg;
    if (started) begin
      eg = !rst && req.req && (init_cnt == NW);
`ifdef SAFE_OBI_RESP_STALL_EN
      eg = eg && !lfsr_m[0];
`endif
      chk("gnt", 32'(resp.gnt), 32'(eg));
      chk("init_done", 32'(init_done), 32'(init_cnt == NW));
      if (resp.rvalid) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rvalid: got rvalid=1 rdata=%h expected no response (cycle %0d)", resp.rdata, cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("rdata", resp.rdata, e.data);
          chk("rvalid_cycle", 32'(cyc), 32'(e.due));
        end
      end else begin
        chk("rdata_idle", resp.rdata, 32'h0);
      end
    end
  end

  task automatic idle(int n);
    req.req = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Present one request, hold it until granted, score it; returns at posedge+1 after accept
  task automatic xfer(bit we, logic [3:0] be, logic [31:0] addr, logic [31:0] wd);
    int   n = 0;
    bit   inr;
    int   ix;
    exp_t e;
    req.req = 1'b1; req.we = we; req.be = be; req.addr = addr; req.wdata = wd;
    forever begin
      @(negedge clk);
      if (resp.gnt) break;
      n++;
      if (n > 4 * NW + 200) begin
        checks++; errors++;
        $display("FAIL grant_timeout: got no gnt for addr %h expected gnt within %0d cycles", addr, n);
        @(posedge clk); #1;
        req.req = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    inr = in_rng(addr);
    ix  = int'(((addr - BASE) >> 2) % NW);
    e.due  = cyc + LAT;
    e.data = we ? 32'h0 : (inr ? mm[ix] : ERR);
    q.push_back(e);
    chk("oor", 32'(oor), 32'(!inr));
    if (we && inr)
      for (int b = 0; b < 4; b++) if (be[b]) mm[ix][8*b +: 8] = wd[8*b +: 8];
    @(posedge clk); #1;
    req.req = 1'b0;
  endtask

  // Two-cycle reset with req held high, then read word 5 once the clear finishes
  task automatic do_reset();
    rst = 1'b1;
    req.req = 1'b1; req.we = 1'b0; req.be = 4'hF; req.addr = BASE + 32'd20; req.wdata = 32'h0;
    q.delete();
    @(posedge clk); #1;
    started = 1;
    @(posedge clk); #1;
    rst = 1'b0;
    foreach (mm[i]) mm[i] = 32'h0;
    xfer(1'b0, 4'hF, BASE + 32'd20, 32'h0);
  endtask

  initial begin
    req = '0;
    rst = 1'b1;
    @(posedge clk); #1;
    do_reset();
    idle(2);

    // Byte-enable write then read back
    xfer(1'b1, 4'b0101, BASE + 32'h10, 32'h1122_3344);
    xfer(1'b0, 4'hF,    BASE + 32'h10, 32'h0);
    idle(LAT + 1);

    // Streaming: 8 writes then 8 reads, all back-to-back
    for (int i = 0; i < 8; i++) xfer(1'b1, 4'hF, BASE + 32'(4 * i), 32'(i));
    for (int i = 0; i < 8; i++) xfer(1'b0, 4'hF, BASE + 32'(4 * i), 32'h0);
    idle(LAT + 1);

    // Out-of-range on both sides, including the top of the address map
    xfer(1'b0, 4'hF, BASE + 32'(NW * 4), 32'h0);
    xfer(1'b1, 4'hF, BASE - 32'd4, 32'hFFFF_FFFF);
    xfer(1'b0, 4'hF, 32'hFFFF_FFFC, 32'h0);
    xfer(1'b0, 4'hF, BASE, 32'h0);
    xfer(1'b0, 4'hF, BASE + 32'(4 * (NW - 1)), 32'h0);
    xfer(1'b1, 4'h0, BASE + 32'h8, 32'hDEAD_BEEF);
    xfer(1'b0, 4'hF, BASE + 32'h8, 32'h0);
    idle(LAT + 1);

    // Reset one cycle after a read grant: the response must never appear
    xfer(1'b1, 4'hF, BASE + 32'h8, 32'hCAFE_F00D);
    xfer(1'b0, 4'hF, BASE + 32'h8, 32'h0);
    do_reset();
    xfer(1'b0, 4'hF, BASE + 32'h8, 32'h0);
    idle(LAT + 1);

    // Random mixed traffic with occasional gaps and out-of-range addresses
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      int sel;
      sel = $urandom_range(0, 9);
      if (sel == 0)      a = BASE - 32'(4 * $urandom_range(1, 4));
      else if (sel == 1) a = BASE + 32'(NW * 4) + 32'($urandom_range(0, 15));
      else               a = BASE + 32'($urandom_range(0, NW * 4 - 1));
      xfer(1'($urandom_range(0, 1)), 4'($urandom), a, $urandom);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    // 100 back-to-back reads
    for (int i = 0; i < 100; i++) xfer(1'b0, 4'hF, BASE + 32'(4 * $urandom_range(0, NW - 1)), 32'h0);
    idle(LAT + 2);
    chk("drain", 32'(q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
